// File: rtl/alu_control_seq.sv
// ALU control decoder with a registered valid/ready handshake and multi-cycle MUL sequencing.
// Defining ALUCTL_STATS_EN adds saturating stat_ops / stat_illegal counters.
module alu_control_seq #(
    parameter int OP_W      = 3,
    parameter int FUNC_W    = 3,
    parameter int MC_CYCLES = 8,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   ALUOp,
    input  logic [FUNC_W-1:0] func,
    input  logic              flush,
    output logic              ctr_valid,
    output logic [2:0]        ALUctr,
    output logic              illegal,
    output logic              mc_busy,
    output logic              mc_done,
`ifdef ALUCTL_STATS_EN
    output logic [15:0]       stat_ops,
    output logic [7:0]        stat_illegal,
`endif
    output logic [1:0]        o_dbg_state
);

    // Handshake: a request is accepted at a rising edge when in_valid && in_ready;
    // its decoded ALUctr/illegal appear after that same edge with ctr_valid high.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SINGLE = 2'd1,
        S_MULTI  = 2'd2
    } state_t;

    localparam logic [2:0] C_AND = 3'b000;
    localparam logic [2:0] C_OR  = 3'b001;
    localparam logic [2:0] C_ADD = 3'b010;
    localparam logic [2:0] C_XOR = 3'b011;
    localparam logic [2:0] C_NOR = 3'b100;
    localparam logic [2:0] C_SLT = 3'b101;
    localparam logic [2:0] C_SUB = 3'b110;
    localparam logic [2:0] C_MUL = 3'b111;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_ctr, w_ctr_nxt;
    logic             r_illegal, w_illegal_nxt;
    logic             r_done, w_done_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic [2:0]       w_code;
    logic             w_dec_ill;
    logic             w_dec_mul;
    logic             w_accept;

    // Combinational decode of the presented request.
    always_comb begin
        w_code    = C_ADD;
        w_dec_ill = 1'b0;
        w_dec_mul = 1'b0;
        if ((ALUOp >> 3) != '0) begin
            w_dec_ill = 1'b1;
        end else if (ALUOp[2:0] == 3'd0) begin
            if ((func >> 3) != '0) begin
                w_dec_ill = 1'b1;
            end else begin
                case (func[2:0])
                    3'd0:    w_code = C_ADD;
                    3'd1:    w_code = C_SUB;
                    3'd2:    w_code = C_AND;
                    3'd3:    w_code = C_OR;
                    3'd4:    w_code = C_SLT;
                    3'd5:    begin w_code = C_MUL; w_dec_mul = 1'b1; end
                    3'd6:    w_code = C_XOR;
                    default: w_dec_ill = 1'b1;
                endcase
            end
        end else begin
            case (ALUOp[2:0])
                3'd1:    w_code = C_ADD;
                3'd2:    w_code = C_SUB;
                3'd3:    w_code = C_AND;
                3'd4:    w_code = C_OR;
                3'd5:    w_code = C_SLT;
                3'd6:    w_code = C_NOR;
                default: w_dec_ill = 1'b1;
            endcase
        end
    end

    assign in_ready = rst_n && (r_state != S_MULTI) && !flush;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_ctr_nxt     = r_ctr;
        w_illegal_nxt = r_illegal;
        w_cnt_nxt     = r_cnt;
        w_done_nxt    = 1'b0;
        if (flush) begin
            w_state_nxt   = S_IDLE;
            w_illegal_nxt = 1'b0;
            w_cnt_nxt     = '0;
        end else begin
            case (r_state)
                S_IDLE, S_SINGLE: begin
                    if (w_accept && w_dec_mul) begin
                        w_state_nxt   = S_MULTI;
                        w_ctr_nxt     = C_MUL;
                        w_illegal_nxt = 1'b0;
                        w_cnt_nxt     = CNT_W'(MC_CYCLES - 1);
                    end else if (w_accept) begin
                        w_state_nxt   = S_SINGLE;
                        w_ctr_nxt     = w_code;
                        w_illegal_nxt = w_dec_ill;
                    end else begin
                        w_state_nxt   = S_IDLE;
                        w_illegal_nxt = 1'b0;
                    end
                end
                S_MULTI: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt  = r_cnt - CNT_W'(1);
                        // mc_done is registered, so raise it one edge before the counter reaches 0
                        w_done_nxt = (r_cnt == CNT_W'(1));
                    end
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_illegal_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ctr     <= 3'b000;
            r_illegal <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ctr     <= w_ctr_nxt;
            r_illegal <= w_illegal_nxt;
            r_done    <= w_done_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign ctr_valid   = (r_state != S_IDLE);
    assign ALUctr      = r_ctr;
    assign illegal     = r_illegal;
    assign mc_busy     = (r_state == S_MULTI);
    assign mc_done     = r_done;
    assign o_dbg_state = r_state;

`ifdef ALUCTL_STATS_EN
    logic [15:0] r_stat_ops;
    logic [7:0]  r_stat_ill;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_ops <= '0;
            r_stat_ill <= '0;
        end else if (w_accept) begin
            if (r_stat_ops != '1) r_stat_ops <= r_stat_ops + 16'd1;
            if (w_dec_ill && (r_stat_ill != '1)) r_stat_ill <= r_stat_ill + 8'd1;
        end
    end

    assign stat_ops     = r_stat_ops;
    assign stat_illegal = r_stat_ill;
`endif

endmodule
